// File: rtl/fpu_pkg.sv
// Shared FP adder definitions: default widths, exponent limit,
// significand bit positions and the normalizer state encoding.
package fpu_pkg;

    localparam int EXP_W      = 11;
    localparam int SIG_W      = 57;
    localparam int SHIFT_STEP = 8;

    localparam logic [EXP_W-1:0] EXP_MAX = '1;

    localparam int CARRY_BIT  = SIG_W - 1;
    localparam int HIDDEN_BIT = SIG_W - 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/lzc_cnt.sv
// Combinational leading-zero counter.
// Ports: i_data (WIDTH bits), o_cnt (CNT_W bits); all-zero input yields WIDTH.
module lzc_cnt #(
    parameter int WIDTH = 56,
    parameter int CNT_W = 6
) (
    input  logic [WIDTH-1:0] i_data,
    output logic [CNT_W-1:0] o_cnt
);

    // Ascending scan: the highest set bit is the last to assign.
    always_comb begin
        o_cnt = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (i_data[i]) begin
                o_cnt = CNT_W'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/sig_normalize.sv
// FP adder post-add normalizer: carry right-shift, bounded left-shift
// with exponent decrement, denormal clamp, zero and overflow flags.
// Ports: clk, rst_n (async low); in_valid/in_ready, in_sig, in_exp;
//        out_valid/out_ready, out_sig, out_exp, out_zero, out_ovf.
module sig_normalize #(
    parameter int EXP_W      = fpu_pkg::EXP_W,
    parameter int SIG_W      = fpu_pkg::SIG_W,
    parameter int SHIFT_STEP = fpu_pkg::SHIFT_STEP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SIG_W-1:0] in_sig,
    input  logic [EXP_W-1:0] in_exp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SIG_W-1:0] out_sig,
    output logic [EXP_W-1:0] out_exp,
    output logic             out_zero,
    output logic             out_ovf
);

    import fpu_pkg::state_t;
    import fpu_pkg::IDLE;
    import fpu_pkg::NORM;
    import fpu_pkg::DONE;

    localparam int CB   = SIG_W - 1;
    localparam int HB   = SIG_W - 2;
    localparam int LZ_W = $clog2(SIG_W);

    localparam logic [EXP_W-1:0] L_EXP_MAX = '1;
    localparam logic [EXP_W-1:0] L_ONE     = EXP_W'(1);
    localparam logic [EXP_W-1:0] L_STEP    = EXP_W'(SHIFT_STEP);

    state_t           r_state;
    state_t           w_state_nxt;

    logic [SIG_W-1:0] r_sig;
    logic [SIG_W-1:0] w_sig_nxt;
    logic [EXP_W-1:0] r_exp;
    logic [EXP_W-1:0] w_exp_nxt;
    logic             r_zero;
    logic             w_zero_nxt;
    logic             r_ovf;
    logic             w_ovf_nxt;

    logic             r_out_valid;
    logic             w_out_valid_nxt;
    logic [SIG_W-1:0] r_out_sig;
    logic [SIG_W-1:0] w_out_sig_nxt;
    logic [EXP_W-1:0] r_out_exp;
    logic [EXP_W-1:0] w_out_exp_nxt;
    logic             r_out_zero;
    logic             w_out_zero_nxt;
    logic             r_out_ovf;
    logic             w_out_ovf_nxt;

    logic [LZ_W-1:0]  w_lz;
    logic [EXP_W-1:0] w_lz_e;
    logic [EXP_W-1:0] w_lim;
    logic [EXP_W-1:0] w_k;

    lzc_cnt #(
        .WIDTH (SIG_W - 1),
        .CNT_W (LZ_W)
    ) u_lzc (
        .i_data (r_sig[HB:0]),
        .o_cnt  (w_lz)
    );

    // Shift this cycle: bounded by leading zeros, per-cycle step and
    // by how far the exponent may fall before reaching 1.
    always_comb begin
        w_lz_e = EXP_W'(w_lz);
        w_lim  = r_exp - L_ONE;
        w_k    = w_lz_e;
        if (L_STEP < w_k) begin
            w_k = L_STEP;
        end
        if (w_lim < w_k) begin
            w_k = w_lim;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_sig_nxt       = r_sig;
        w_exp_nxt       = r_exp;
        w_zero_nxt      = r_zero;
        w_ovf_nxt       = r_ovf;
        w_out_valid_nxt = r_out_valid;
        w_out_sig_nxt   = r_out_sig;
        w_out_exp_nxt   = r_out_exp;
        w_out_zero_nxt  = r_out_zero;
        w_out_ovf_nxt   = r_out_ovf;

        unique case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_sig_nxt   = in_sig;
                    w_exp_nxt   = (in_exp == '0) ? L_ONE : in_exp;
                    w_zero_nxt  = 1'b0;
                    w_ovf_nxt   = 1'b0;
                    w_state_nxt = NORM;
                end
            end

            NORM: begin
                if (r_sig == '0) begin
                    w_exp_nxt   = '0;
                    w_zero_nxt  = 1'b1;
                    w_state_nxt = DONE;
                end else if (r_sig[CB]) begin
                    // Bit shifted out folds into sticky.
                    w_sig_nxt = {1'b0, r_sig[CB:2],
                                 r_sig[1] | r_sig[0]};
                    // Saturate rather than wrap past all-ones.
                    if (r_exp >= L_EXP_MAX - L_ONE) begin
                        w_exp_nxt = L_EXP_MAX;
                        w_sig_nxt = '0;
                        w_ovf_nxt = 1'b1;
                    end else begin
                        w_exp_nxt = r_exp + L_ONE;
                    end
                    w_state_nxt = DONE;
                end else if (r_sig[HB]) begin
                    w_state_nxt = DONE;
                end else if (r_exp <= L_ONE) begin
                    w_exp_nxt   = '0;
                    w_state_nxt = DONE;
                end else begin
                    w_sig_nxt = r_sig << w_k;
                    w_exp_nxt = r_exp - w_k;
                end
            end

            DONE: begin
                // First DONE cycle publishes the result registers.
                if (!r_out_valid) begin
                    w_out_valid_nxt = 1'b1;
                    w_out_sig_nxt   = r_sig;
                    w_out_exp_nxt   = r_exp;
                    w_out_zero_nxt  = r_zero;
                    w_out_ovf_nxt   = r_ovf;
                end else if (out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_state_nxt     = IDLE;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_sig       <= '0;
            r_exp       <= '0;
            r_zero      <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_sig   <= '0;
            r_out_exp   <= '0;
            r_out_zero  <= 1'b0;
            r_out_ovf   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sig       <= w_sig_nxt;
            r_exp       <= w_exp_nxt;
            r_zero      <= w_zero_nxt;
            r_ovf       <= w_ovf_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_sig   <= w_out_sig_nxt;
            r_out_exp   <= w_out_exp_nxt;
            r_out_zero  <= w_out_zero_nxt;
            r_out_ovf   <= w_out_ovf_nxt;
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = r_out_valid;
    assign out_sig   = r_out_sig;
    assign out_exp   = r_out_exp;
    assign out_zero  = r_out_zero;
    assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_sig_normalize.sv
// Self-checking bench for sig_normalize: directed vectors, an
// arithmetic reference model and a per-cycle output checker.
module tb_sig_normalize;

    localparam int EW = 11;
    localparam int SW = 57;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [SW-1:0] in_sig = '0;
    logic [EW-1:0] in_exp = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [SW-1:0] out_sig;
    logic [EW-1:0] out_exp;
    logic          out_zero;
    logic          out_ovf;

    sig_normalize dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sig    (in_sig),
        .in_exp    (in_exp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sig   (out_sig),
        .out_exp   (out_exp),
        .out_zero  (out_zero),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [SW-1:0] sig;
        logic [EW-1:0] ex;
        logic          zero;
        logic          ovf;
        int            lat;
    } res_t;

    typedef struct {
        logic [SW-1:0] isig;
        logic [EW-1:0] iexp;
        res_t          r;
        int            hold;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_err = 0;
    int   cyc = 0;
    bit   busy = 1'b0;
    int   t_acc = 0;
    res_t cur;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic logic [SW-1:0] p2(int n);
        logic [SW-1:0] one;
        one = SW'(1);
        return one << n;
    endfunction

    // Reference: normalize in one go, then derive latency from the
    // total left-shift distance split into 8-bit steps.
    function automatic res_t model(logic [SW-1:0] s, logic [EW-1:0] e);
        res_t r;
        int   ee;
        int   msb;
        int   a;
        int   l;
        r.zero = 1'b0;
        r.ovf  = 1'b0;
        r.lat  = 2;
        if (s == '0) begin
            r.sig  = '0;
            r.ex   = '0;
            r.zero = 1'b1;
            return r;
        end
        if (s[SW-1]) begin
            r.sig = (s >> 1) | (s & SW'(1));
            ee = int'(e) + 1;
            if (ee >= 2047) begin
                r.sig = '0;
                ee    = 2047;
                r.ovf = 1'b1;
            end
            r.ex = EW'(ee);
            return r;
        end
        ee  = (e == '0) ? 1 : int'(e);
        msb = 0;
        for (int i = 0; i < SW - 1; i++) begin
            if (s[i]) msb = i;
        end
        l = SW - 2 - msb;
        a = (l < ee - 1) ? l : ee - 1;
        r.sig = s << a;
        ee = ee - a;
        if (!r.sig[SW-2]) ee = 0;
        r.ex  = EW'(ee);
        r.lat = 2 + (a + 7) / 8;
        return r;
    endfunction

    task automatic add(logic [SW-1:0] is, int ie, logic [SW-1:0] es,
                       int ee, bit z, bit o, int lat, int hold);
        vec_t v;
        v.isig   = is;
        v.iexp   = EW'(ie);
        v.r.sig  = es;
        v.r.ex   = EW'(ee);
        v.r.zero = z;
        v.r.ovf  = o;
        v.r.lat  = lat;
        v.hold   = hold;
        vecs.push_back(v);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) begin
                chk("in_ready_busy", 64'(in_ready), 64'd0);
                chk("out_valid_timing", 64'(out_valid),
                    64'(cyc >= t_acc + cur.lat));
                if (out_valid) begin
                    chk("out_sig", 64'(out_sig), 64'(cur.sig));
                    chk("out_exp", 64'(out_exp), 64'(cur.ex));
                    chk("out_zero", 64'(out_zero), 64'(cur.zero));
                    chk("out_ovf", 64'(out_ovf), 64'(cur.ovf));
                end
            end else begin
                chk("in_ready_idle", 64'(in_ready), 64'd1);
                chk("out_valid_idle", 64'(out_valid), 64'd0);
            end
        end
    end

    task automatic accept(logic [SW-1:0] s, logic [EW-1:0] e);
        in_sig   = s;
        in_exp   = e;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        t_acc    = cyc;
        cur      = model(s, e);
        busy     = 1'b1;
    endtask

    task automatic run_vec(vec_t v);
        int n;
        accept(v.isig, v.iexp);
        n = 0;
        while (!out_valid && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!out_valid) begin
            chk("out_valid_timeout", 64'(out_valid), 64'd1);
            busy  = 1'b0;
            rst_n = 1'b0;
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            return;
        end
        if (v.hold > 0) begin
            in_valid = 1'b1;
            in_sig   = ~v.isig;
            in_exp   = EW'(3);
            repeat (v.hold) begin
                @(posedge clk);
                #1;
            end
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        busy      = 1'b0;
    endtask

    task automatic chk_reset_vals(string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_out_sig"}, 64'(out_sig), 64'd0);
        chk({tag, "_out_exp"}, 64'(out_exp), 64'd0);
        chk({tag, "_out_zero"}, 64'(out_zero), 64'd0);
        chk({tag, "_out_ovf"}, 64'(out_ovf), 64'd0);
    endtask

    initial begin
        res_t r;

        add(p2(56) | SW'(1), 10, p2(55) | SW'(1), 11, 0, 0, 2, 0);
        add(p2(55) | SW'(5), 100, p2(55) | SW'(5), 100, 0, 0, 2, 0);
        add(p2(35), 100, p2(55), 80, 0, 0, 5, 0);
        add(p2(40), 5, p2(44), 0, 0, 0, 3, 0);
        add(p2(30), 0, p2(30), 0, 0, 0, 2, 0);
        add('0, 500, '0, 0, 1, 0, 2, 0);
        add(p2(56), 2046, '0, 2047, 0, 1, 2, 0);
        add(p2(56) | p2(55) | SW'(3), 7,
            p2(55) | p2(54) | SW'(1), 8, 0, 0, 2, 0);
        add(p2(47), 20, p2(55), 12, 0, 0, 3, 0);
        add(p2(50), 6, p2(55), 1, 0, 0, 3, 0);
        add(SW'(1), 1000, p2(55), 945, 0, 0, 9, 0);
        add(p2(52) | p2(10), 50, p2(55) | p2(13), 47, 0, 0, 3, 5);
        add(p2(54), 1, p2(54), 0, 0, 0, 2, 0);

        foreach (vecs[i]) begin
            r = model(vecs[i].isig, vecs[i].iexp);
            chk("model_sig", 64'(r.sig), 64'(vecs[i].r.sig));
            chk("model_exp", 64'(r.ex), 64'(vecs[i].r.ex));
            chk("model_zero", 64'(r.zero), 64'(vecs[i].r.zero));
            chk("model_ovf", 64'(r.ovf), 64'(vecs[i].r.ovf));
            chk("model_lat", 64'(r.lat), 64'(vecs[i].r.lat));
        end

        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            run_vec(vecs[i]);
        end

        accept(p2(35), EW'(100));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        busy  = 1'b0;
        #1;
        chk_reset_vals("midnorm_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_vec(vecs[2]);
        run_vec(vecs[0]);

        repeat (2) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule
